// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, state encoding and requester index for the register-file write arbiter.
package rf_pkg;
  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADD_WIDTH  = 5;
  typedef enum logic {CLEAR, ARB} state_e;
  typedef logic req_idx_t;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: two valid/ready write requesters (ALU and load writeback) into the arbiter.
interface rf_write_arbiter_if #(
  parameter int DATA_WIDTH = rf_pkg::RF_DATA_WIDTH,
  parameter int ADD_WIDTH  = rf_pkg::RF_ADD_WIDTH
);
  logic                  req0_valid;
  logic [ADD_WIDTH-1:0]  req0_addr;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [ADD_WIDTH-1:0]  req1_addr;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_ready;
  modport master (
    output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready
  );
  modport slave (
    input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/rf_write_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin grant; the pointer names the requester favoured on contention.
module rr_arb2
  import rf_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic v0_i,
  input  logic v1_i,
  output logic g0_o,
  output logic g1_o
);
  req_idx_t ptr_q, ptr_d;
  always_comb begin
    g0_o  = en_i & v0_i & (~v1_i | ~ptr_q);
    g1_o  = en_i & v1_i & (~v0_i | ptr_q);
    ptr_d = g0_o ? 1'b1 : g1_o ? 1'b0 : ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: arbitrates two writeback requesters onto one registered RF write port.
// Define RF_WRITE_ARB_CLEAR_EN to zero registers 1..2**ADD_WIDTH-1 after reset before arbitrating.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADD_WIDTH  = RF_ADD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rf_write_arbiter_if.slave     req,
  output logic                  WE3,
  output logic [ADD_WIDTH-1:0]  AD3,
  output logic [DATA_WIDTH-1:0] WD3,
  output logic                  busy
);
  logic                  g0, g1, arb_en, wr;
  logic [ADD_WIDTH-1:0]  wa;
  logic [DATA_WIDTH-1:0] wdat;
  logic                  we_q;
  logic [ADD_WIDTH-1:0]  ad_q;
  logic [DATA_WIDTH-1:0] wd_q;
`ifdef RF_WRITE_ARB_CLEAR_EN
  state_e               state_q;
  logic [ADD_WIDTH-1:0] cnt_q;
  assign arb_en = rst_n & (state_q == ARB);
  assign busy   = state_q == CLEAR;
`else
  assign arb_en = rst_n;
  assign busy   = 1'b0;
`endif
  rr_arb2 u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .en_i (arb_en),
    .v0_i (req.req0_valid),
    .v1_i (req.req1_valid),
    .g0_o (g0),
    .g1_o (g1)
  );
  assign req.req0_ready = g0;
  assign req.req1_ready = g1;
  assign wa   = g1 ? req.req1_addr : req.req0_addr;
  assign wdat = g1 ? req.req1_data : req.req0_data;
  // x0 is hardwired: the handshake completes but nothing is written
  assign wr   = (g0 | g1) & (|wa);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      we_q <= 1'b0;
      ad_q <= '0;
      wd_q <= '0;
`ifdef RF_WRITE_ARB_CLEAR_EN
      state_q <= CLEAR;
      cnt_q   <= ADD_WIDTH'(1);
`endif
    end
`ifdef RF_WRITE_ARB_CLEAR_EN
    else if (state_q == CLEAR) begin
      we_q  <= 1'b1;
      ad_q  <= cnt_q;
      wd_q  <= '0;
      cnt_q <= cnt_q + 1'b1;
      if (&cnt_q) state_q <= ARB;
    end
`endif
    else begin
      we_q <= wr;
      if (wr) begin
        ad_q <= wa;
        wd_q <= wdat;
      end
    end
  assign WE3 = we_q;
  assign AD3 = ad_q;
  assign WD3 = wd_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed scoreboard bench; also covers the clear sequence when RF_WRITE_ARB_CLEAR_EN is defined.
module tb_rf_write_arbiter;
  import rf_pkg::*;
  localparam int DW = RF_DATA_WIDTH;
  localparam int AW = RF_ADD_WIDTH;
  typedef struct {
    logic          we;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
  } wr_t;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          we3, busy;
  logic [AW-1:0] ad3;
  logic [DW-1:0] wd3;
  wr_t           exp_q[$];
  logic          ptr_m = 1'b0;
  logic [AW-1:0] hold_ad = '0;
  logic [DW-1:0] hold_wd = '0;
  int            n_tests = 0;
  int            n_fail = 0;
  rf_write_arbiter_if #(.DATA_WIDTH(DW), .ADD_WIDTH(AW)) bus ();
  rf_write_arbiter #(.DATA_WIDTH(DW), .ADD_WIDTH(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (bus),
    .WE3  (we3),
    .AD3  (ad3),
    .WD3  (wd3),
    .busy (busy)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
  endtask

  task automatic cycle(input string tag);
    logic          g0, g1;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    wr_t           e;
    #1;
    g0 = bus.req0_valid & (!bus.req1_valid | !ptr_m);
    g1 = bus.req1_valid & (!bus.req0_valid | ptr_m);
    chk({tag, ".rdy0"}, bus.req0_ready, g0);
    chk({tag, ".rdy1"}, bus.req1_ready, g1);
    chk({tag, ".busy"}, busy, 1'b0);
    e.we = 1'b0;
    if (g0 | g1) begin
      ptr_m = g0;
      a = g0 ? bus.req0_addr : bus.req1_addr;
      d = g0 ? bus.req0_data : bus.req1_data;
      if (a != 0) begin
        e.we = 1'b1;
        hold_ad = a;
        hold_wd = d;
      end
    end
    e.ad = hold_ad;
    e.wd = hold_wd;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".we3"}, we3, e.we);
    chk({tag, ".ad3"}, ad3, e.ad);
    chk({tag, ".wd3"}, wd3, e.wd);
  endtask

  task automatic assert_reset(input string tag);
    rst_n = 1'b0;
    ptr_m = 1'b0;
    hold_ad = '0;
    hold_wd = '0;
    exp_q.delete();
    #1;
    chk({tag, ".we3"}, we3, 1'b0);
    chk({tag, ".ad3"}, ad3, '0);
    chk({tag, ".wd3"}, wd3, '0);
    chk({tag, ".rdy0"}, bus.req0_ready, 1'b0);
    chk({tag, ".rdy1"}, bus.req1_ready, 1'b0);
  endtask

  task automatic clear_seq(input int n);
    for (int i = 1; i <= n; i++) begin
      chk("clr.rdy0", bus.req0_ready, 1'b0);
      chk("clr.rdy1", bus.req1_ready, 1'b0);
      chk("clr.busy", busy, 1'b1);
      @(posedge clk);
      #1;
      chk("clr.we3", we3, 1'b1);
      chk("clr.ad3", ad3, i[AW-1:0]);
      chk("clr.wd3", wd3, '0);
    end
    if (n == (1 << AW) - 1) begin
      chk("clr.busy_end", busy, 1'b0);
      hold_ad = '1;
      hold_wd = '0;
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
`ifdef RF_WRITE_ARB_CLEAR_EN
    clear_seq((1 << AW) - 1);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(1'b1, 5'd7, 32'h77, 1'b0, '0, '0);
    #12;
    assert_reset("rst");
    release_reset();
    cycle("first");
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    cycle("single0");
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    cycle("idle");
    drive(1'b0, '0, '0, 1'b1, 5'd0, 32'h1234);
    cycle("x0");
    drive(1'b0, '0, '0, 1'b1, 5'd12, 32'hCAFE);
    cycle("single1");
    assert_reset("rst2");
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    release_reset();
    for (int i = 0; i < 4; i++) cycle("cont");
    drive(1'b1, 5'd9, 32'h99, 1'b0, '0, '0);
    #1;
    chk("xfer.rdy0", bus.req0_ready, 1'b1);
    assert_reset("rst_xfer");
    @(posedge clk);
    #1;
    chk("rst_xfer.we3_hold", we3, 1'b0);
    chk("rst_xfer.ad3_hold", ad3, '0);
    release_reset();
    cycle("post_xfer");
`ifdef RF_WRITE_ARB_CLEAR_EN
    assert_reset("rst3");
    @(negedge clk);
    rst_n = 1'b1;
    clear_seq(9);
    assert_reset("rst_clr");
    release_reset();
    cycle("post_clr");
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
